// File: rtl/mix_train_seq.sv
// Training-step sequencer for one mix block: zero_grad, forward, backward-load,
// backward and optional update phases, each guarded by a watchdog.
module mix_train_seq #(
    parameter int                   TIMEOUT   = 4096,
    parameter int                   STATE_LEN = 4,
    parameter logic [STATE_LEN-1:0] F_MIX1    = STATE_LEN'(1),
    parameter logic [STATE_LEN-1:0] F_MIX2    = STATE_LEN'(2),
    parameter logic [STATE_LEN-1:0] F_MIX3    = STATE_LEN'(3),
    parameter logic [STATE_LEN-1:0] B_MIX1    = STATE_LEN'(4),
    parameter logic [STATE_LEN-1:0] B_MIX2    = STATE_LEN'(5),
    parameter logic [STATE_LEN-1:0] B_MIX3    = STATE_LEN'(6)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 do_zero,
    input  logic                 do_update,
    input  logic                 abort,
    input  logic                 valid_zero_grad,
    input  logic                 valid_forward,
    input  logic                 valid_backward,
    input  logic                 valid_update,
    output logic                 zero_grad,
    output logic                 run_forward,
    output logic                 run_backward,
    output logic                 load_backward,
    output logic                 update,
    output logic [STATE_LEN-1:0] state_forward,
    output logic [STATE_LEN-1:0] state_backward,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    // state  | meaning
    // IDLE   | waiting for start
    // ZERO   | zero_grad asserted, waiting for valid_zero_grad
    // F1..F3 | forward over MIX1..MIX3, waiting for valid_forward
    // LOADB  | one-cycle backward-input capture
    // B3..B1 | backward over MIX3..MIX1, waiting for valid_backward
    // U1..U3 | optimizer update over MIX1..MIX3, waiting for valid_update
    // GAP    | all strobes low for one cycle, then gap_next
    // DONE   | done pulse, codes cleared
    // ERR    | watchdog expired, held until abort or reset
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_ZERO  = 4'd1;
    localparam logic [3:0] S_F1    = 4'd2;
    localparam logic [3:0] S_F2    = 4'd3;
    localparam logic [3:0] S_F3    = 4'd4;
    localparam logic [3:0] S_LOADB = 4'd5;
    localparam logic [3:0] S_B3    = 4'd6;
    localparam logic [3:0] S_B2    = 4'd7;
    localparam logic [3:0] S_B1    = 4'd8;
    localparam logic [3:0] S_U1    = 4'd9;
    localparam logic [3:0] S_U2    = 4'd10;
    localparam logic [3:0] S_U3    = 4'd11;
    localparam logic [3:0] S_GAP   = 4'd12;
    localparam logic [3:0] S_DONE  = 4'd13;
    localparam logic [3:0] S_ERR   = 4'd14;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [3:0]       state, state_nxt;
    logic [3:0]       gap_next, gap_next_nxt;
    logic             upd_lat, upd_lat_nxt;
    logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt, wd_inc;
    logic             waiting, phase_valid, expired;
    logic [3:0]       succ;

    always_comb begin
        waiting     = 1'b0;
        phase_valid = 1'b0;
        succ        = S_IDLE;
        case (state)
            S_ZERO: begin waiting = 1'b1; phase_valid = valid_zero_grad; succ = S_F1;    end
            S_F1:   begin waiting = 1'b1; phase_valid = valid_forward;   succ = S_F2;    end
            S_F2:   begin waiting = 1'b1; phase_valid = valid_forward;   succ = S_F3;    end
            S_F3:   begin waiting = 1'b1; phase_valid = valid_forward;   succ = S_LOADB; end
            S_B3:   begin waiting = 1'b1; phase_valid = valid_backward;  succ = S_B2;    end
            S_B2:   begin waiting = 1'b1; phase_valid = valid_backward;  succ = S_B1;    end
            S_B1: begin
                waiting     = 1'b1;
                phase_valid = valid_backward;
                succ        = upd_lat ? S_U1 : S_DONE;
            end
            S_U1:   begin waiting = 1'b1; phase_valid = valid_update;    succ = S_U2;    end
            S_U2:   begin waiting = 1'b1; phase_valid = valid_update;    succ = S_U3;    end
            S_U3:   begin waiting = 1'b1; phase_valid = valid_update;    succ = S_DONE;  end
            default: ;
        endcase
    end

    // Counter holds the number of completed wait cycles; the TIMEOUT-th one trips ERR.
    assign wd_inc  = wd_cnt + CNT_W'(1);
    assign expired = (wd_inc == CNT_W'(TIMEOUT));

    always_comb begin
        state_nxt    = state;
        gap_next_nxt = gap_next;
        upd_lat_nxt  = upd_lat;
        wd_cnt_nxt   = wd_cnt;
        if (abort) begin
            state_nxt   = S_IDLE;
            upd_lat_nxt = 1'b0;
            wd_cnt_nxt  = '0;
        end else if (waiting) begin
            if (phase_valid) begin
                state_nxt    = S_GAP;
                gap_next_nxt = succ;
            end else if (expired) begin
                state_nxt = S_ERR;
            end else begin
                wd_cnt_nxt = wd_inc;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        upd_lat_nxt = do_update;
                        state_nxt   = do_zero ? S_ZERO : S_F1;
                        wd_cnt_nxt  = '0;
                    end
                end
                S_GAP: begin
                    state_nxt  = gap_next;
                    wd_cnt_nxt = '0;
                end
                S_LOADB: begin
                    state_nxt  = S_B3;
                    wd_cnt_nxt = '0;
                end
                S_DONE:  state_nxt = S_IDLE;
                S_ERR:   state_nxt = S_ERR;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            gap_next       <= S_IDLE;
            upd_lat        <= 1'b0;
            wd_cnt         <= '0;
            zero_grad      <= 1'b0;
            run_forward    <= 1'b0;
            run_backward   <= 1'b0;
            load_backward  <= 1'b0;
            update         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            state_forward  <= '0;
            state_backward <= '0;
        end else begin
            state         <= state_nxt;
            gap_next      <= gap_next_nxt;
            upd_lat       <= upd_lat_nxt;
            wd_cnt        <= wd_cnt_nxt;
            zero_grad     <= (state_nxt == S_ZERO);
            run_forward   <= (state_nxt == S_F1) || (state_nxt == S_F2) || (state_nxt == S_F3);
            run_backward  <= (state_nxt == S_B3) || (state_nxt == S_B2) || (state_nxt == S_B1);
            load_backward <= (state_nxt == S_LOADB);
            update        <= (state_nxt == S_U1) || (state_nxt == S_U2) || (state_nxt == S_U3);
            busy          <= (state_nxt != S_IDLE) && (state_nxt != S_ERR);
            done          <= (state_nxt == S_DONE);
            err           <= (state_nxt == S_ERR);
            // Codes change only on phase entry; GAP, LOADB and ERR keep the last ones.
            case (state_nxt)
                S_F1: state_forward  <= F_MIX1;
                S_F2: state_forward  <= F_MIX2;
                S_F3: state_forward  <= F_MIX3;
                S_B3: state_backward <= B_MIX3;
                S_B2: state_backward <= B_MIX2;
                S_B1: state_backward <= B_MIX1;
                S_U1: state_backward <= B_MIX1;
                S_U2: state_backward <= B_MIX2;
                S_U3: state_backward <= B_MIX3;
                S_IDLE, S_DONE: begin
                    state_forward  <= '0;
                    state_backward <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_train_seq.sv
// Bench for mix_train_seq: a phase-list reference model predicts every output cycle
// while a responder plays the mix block's valid handshakes.
module tb_mix_train_seq;

    localparam int TMO = 16;
    localparam int SL  = 4;
    localparam logic [SL-1:0] FM1 = 4'd1, FM2 = 4'd2, FM3 = 4'd3;
    localparam logic [SL-1:0] BM1 = 4'd9, BM2 = 4'd10, BM3 = 4'd11;

    logic clk, rst_n, start, do_zero, do_update, abort;
    logic valid_zero_grad, valid_forward, valid_backward, valid_update;
    logic zero_grad, run_forward, run_backward, load_backward, update;
    logic [SL-1:0] state_forward, state_backward;
    logic busy, done, err;

    mix_train_seq #(
        .TIMEOUT(TMO), .STATE_LEN(SL),
        .F_MIX1(FM1), .F_MIX2(FM2), .F_MIX3(FM3),
        .B_MIX1(BM1), .B_MIX2(BM2), .B_MIX3(BM3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .do_zero(do_zero),
        .do_update(do_update), .abort(abort),
        .valid_zero_grad(valid_zero_grad), .valid_forward(valid_forward),
        .valid_backward(valid_backward), .valid_update(valid_update),
        .zero_grad(zero_grad), .run_forward(run_forward), .run_backward(run_backward),
        .load_backward(load_backward), .update(update),
        .state_forward(state_forward), .state_backward(state_backward),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic zg, rf, rb, lb, up;
        logic [SL-1:0] sf, sb;
        logic busy, done, err;
    } out_t;

    typedef int dly_t[10];  // phase order: zero, F1, F2, F3, B3, B2, B1, U1, U2, U3

    typedef struct {
        bit dz, du;
        int d;
        int lat;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    out_t exp_q[$];
    int   prev_id;
    int   run_cnt;

    function automatic out_t mk(logic zg, logic rf, logic rb, logic lb, logic up,
                                logic [SL-1:0] sf, logic [SL-1:0] sb,
                                logic bsy, logic dn, logic er);
        out_t o;
        o.zg = zg; o.rf = rf; o.rb = rb; o.lb = lb; o.up = up;
        o.sf = sf; o.sb = sb; o.busy = bsy; o.done = dn; o.err = er;
        return o;
    endfunction

    function automatic out_t dut_out();
        return mk(zero_grad, run_forward, run_backward, load_backward, update,
                  state_forward, state_backward, busy, done, err);
    endfunction

    task automatic check_out(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [SL-1:0] code_of(int p);
        case (p)
            1: return FM1;
            2: return FM2;
            3: return FM3;
            4: return BM3;
            5: return BM2;
            6: return BM1;
            7: return BM1;
            8: return BM2;
            9: return BM3;
            default: return '0;
        endcase
    endfunction

    // Expected per-cycle outputs from the cycle after start onward.
    task automatic build_trace(input bit dz, input bit du, input dly_t dly);
        int order[$];
        logic [SL-1:0] sf, sb;
        out_t o;
        exp_q.delete();
        sf = '0;
        sb = '0;
        if (dz) order.push_back(0);
        for (int p = 1; p <= 6; p++) order.push_back(p);
        if (du) for (int p = 7; p <= 9; p++) order.push_back(p);
        foreach (order[k]) begin
            int p;
            p = order[k];
            if (p >= 1 && p <= 3) sf = code_of(p);
            if (p >= 4) sb = code_of(p);
            o = mk(p == 0, p >= 1 && p <= 3, p >= 4 && p <= 6, 1'b0, p >= 7,
                   sf, sb, 1'b1, 1'b0, 1'b0);
            if (dly[p] >= TMO) begin
                for (int c = 0; c < TMO; c++) exp_q.push_back(o);
                exp_q.push_back(mk(0, 0, 0, 0, 0, sf, sb, 1'b0, 1'b0, 1'b1));
                return;
            end
            for (int c = 0; c <= dly[p]; c++) exp_q.push_back(o);
            exp_q.push_back(mk(0, 0, 0, 0, 0, sf, sb, 1'b1, 1'b0, 1'b0));
            if (p == 3) exp_q.push_back(mk(0, 0, 0, 1, 0, sf, sb, 1'b1, 1'b0, 1'b0));
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0, '0, '0, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, '0, '0, 1'b0, 1'b0, 1'b0));
    endtask

    // Mix block: answer each phase dly[phase] cycles after its strobe rises.
    task automatic respond(input dly_t dly, input bit noise);
        int id;
        id = -1;
        if (zero_grad) id = 0;
        else if (run_forward) begin
            for (int p = 1; p <= 3; p++) if (state_forward == code_of(p)) id = p;
        end else if (run_backward) begin
            for (int p = 4; p <= 6; p++) if (state_backward == code_of(p)) id = p;
        end else if (update) begin
            for (int p = 7; p <= 9; p++) if (state_backward == code_of(p)) id = p;
        end
        if (id >= 0 && id == prev_id) run_cnt++;
        else run_cnt = 0;
        prev_id = id;
        valid_zero_grad = 1'b0;
        valid_forward   = 1'b0;
        valid_backward  = 1'b0;
        valid_update    = 1'b0;
        if (id >= 0) begin
            if (run_cnt == dly[id]) begin
                if (id == 0) valid_zero_grad = 1'b1;
                else if (id <= 3) valid_forward = 1'b1;
                else if (id <= 6) valid_backward = 1'b1;
                else valid_update = 1'b1;
            end
        end else if (noise) begin
            valid_zero_grad = 1'($urandom_range(0, 1));
            valid_forward   = 1'($urandom_range(0, 1));
            valid_backward  = 1'($urandom_range(0, 1));
            valid_update    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic clear_valids();
        valid_zero_grad = 1'b0;
        valid_forward   = 1'b0;
        valid_backward  = 1'b0;
        valid_update    = 1'b0;
    endtask

    // Entered and left #1 after a rising edge. cut > 0 stops after that many cycles.
    task automatic run_step(input bit dz, input bit du, input dly_t dly, input int cut,
                            input bit noise, output int done_cyc);
        int lim;
        build_trace(dz, du, dly);
        lim = (cut > 0) ? cut : exp_q.size();
        done_cyc  = -1;
        prev_id   = -1;
        run_cnt   = 0;
        start     = 1'b1;
        do_zero   = dz;
        do_update = du;
        for (int i = 1; i <= lim; i++) begin
            @(posedge clk);
            #1;
            start     = (noise && i < lim) ? 1'($urandom_range(0, 1)) : 1'b0;
            do_zero   = 1'($urandom_range(0, 1));
            do_update = 1'($urandom_range(0, 1));
            check_out($sformatf("step_cyc%0d", i), dut_out(), exp_q[i-1]);
            if (done && done_cyc < 0) done_cyc = i;
            respond(dly, noise);
        end
        start = 1'b0;
        clear_valids();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t tbl[6];
        dly_t dly;
        int dc;
        out_t zero_o;

        zero_o = mk(0, 0, 0, 0, 0, '0, '0, 0, 0, 0);
        rst_n = 1'b0; start = 1'b0; do_zero = 1'b0; do_update = 1'b0; abort = 1'b0;
        clear_valids();

        tbl[0] = '{dz: 1, du: 1, d: 0, lat: 23};
        tbl[1] = '{dz: 0, du: 0, d: 0, lat: 15};
        tbl[2] = '{dz: 1, du: 1, d: 5, lat: 73};
        tbl[3] = '{dz: 0, du: 0, d: 5, lat: 45};
        tbl[4] = '{dz: 1, du: 0, d: 2, lat: 31};
        tbl[5] = '{dz: 0, du: 1, d: 1, lat: 30};

        repeat (2) tick();
        check_out("reset_outputs", dut_out(), zero_o);
        rst_n = 1'b1;
        tick();
        tick();
        check_out("idle_after_reset", dut_out(), zero_o);

        for (int t = 0; t < 6; t++) begin
            foreach (dly[k]) dly[k] = tbl[t].d;
            run_step(tbl[t].dz, tbl[t].du, dly, 0, 1'b0, dc);
            check_int($sformatf("latency_vec%0d", t), dc + 1, tbl[t].lat);
        end

        for (int t = 0; t < 8; t++) begin
            bit dz, du;
            dz = 1'($urandom_range(0, 1));
            du = 1'($urandom_range(0, 1));
            foreach (dly[k]) dly[k] = $urandom_range(0, 6);
            run_step(dz, du, dly, 0, 1'b1, dc);
        end

        // Watchdog: B2 never answers.
        foreach (dly[k]) dly[k] = 0;
        dly[5] = 1000;
        run_step(1'b0, 1'b0, dly, 0, 1'b0, dc);
        for (int c = 0; c < 4; c++) begin
            start = 1'b1;
            tick();
            check_int("err_held", {err, busy, zero_grad, run_forward, run_backward,
                                   load_backward, update, done}, 32'h80);
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_out("abort_from_err", dut_out(), zero_o);
        tick();
        check_out("idle_after_err_abort", dut_out(), zero_o);

        // Abort in F2 together with valid_forward.
        start = 1'b1; do_zero = 1'b0; do_update = 1'b0;
        tick();
        start = 1'b0;
        check_out("abort_seq_f1", dut_out(), mk(0, 1, 0, 0, 0, FM1, '0, 1, 0, 0));
        valid_forward = 1'b1;
        tick();
        valid_forward = 1'b0;
        check_out("abort_seq_gap", dut_out(), mk(0, 0, 0, 0, 0, FM1, '0, 1, 0, 0));
        tick();
        check_out("abort_seq_f2a", dut_out(), mk(0, 1, 0, 0, 0, FM2, '0, 1, 0, 0));
        tick();
        check_out("abort_seq_f2b", dut_out(), mk(0, 1, 0, 0, 0, FM2, '0, 1, 0, 0));
        valid_forward = 1'b1;
        abort = 1'b1;
        tick();
        valid_forward = 1'b0;
        abort = 1'b0;
        check_out("abort_to_idle", dut_out(), zero_o);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_out("abort_stays_idle", dut_out(), zero_o);
        end

        // Reset in the middle of U2.
        foreach (dly[k]) dly[k] = 3;
        run_step(1'b1, 1'b1, dly, 43, 1'b0, dc);
        check_int("in_u2_before_reset", {update, state_backward}, {1'b1, BM2});
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset_outputs", dut_out(), zero_o);
        tick();
        rst_n = 1'b1;
        tick();
        check_out("idle_after_midstep_reset", dut_out(), zero_o);
        foreach (dly[k]) dly[k] = 0;
        run_step(1'b1, 1'b1, dly, 0, 1'b0, dc);
        check_int("latency_after_reset", dc + 1, 23);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
